// File: rtl/framebuffer_dumper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_dumper_pkg
// Description : Shared definitions for the framebuffer readback path.
//               Holds the dump engine state encoding and the framebuffer
//               geometry constants. The UART-to-framebuffer write path uses
//               the same constants for its address wrap point.
// Revision    : 1.0 - initial release
// ============================================================================
package framebuffer_dumper_pkg;

    // Framebuffer geometry shared by the write path and the dump engine.
    localparam int FB_BYTES      = 9600;
    localparam int FB_ADDR_WIDTH = 14;

    // Dump engine states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        CAPTURE  = 3'd2,
        LOAD     = 3'd3,
        WAIT_ACK = 3'd4,
        WAIT_RDY = 3'd5,
        CSUM     = 3'd6,
        DONE     = 3'd7
    } dump_state_t;

endpackage
`default_nettype wire

// File: rtl/framebuffer_dumper.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_dumper
// Description : Single-shot engine that reads the whole framebuffer RAM in
//               address order and streams each byte to the UART transmitter,
//               optionally followed by an XOR checksum byte.
//
// Ports
//   clk              in   system clock
//   reset            in   asynchronous active-high reset
//   start            in   one-cycle dump request, only sampled when idle
//   busy             out  high for the duration of a dump
//   done             out  one-cycle pulse after the last byte is taken
//   ram_read_address out  registered RAM read address
//   ram_q            in   RAM read data, valid one cycle after the address
//   tx_data          out  byte presented to the UART (registered)
//   tx_load          out  one-cycle UART load strobe
//   tx_ready         in   high while the UART can accept a byte
//
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_dumper
    import framebuffer_dumper_pkg::*;
#(
    parameter int FB_SIZE       = FB_BYTES,
    parameter int ADDR_WIDTH    = FB_ADDR_WIDTH,
    parameter int RAM_WORD_SIZE = 8,
    parameter bit SEND_CHECKSUM = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_WIDTH-1:0]    ram_read_address,
    input  logic [RAM_WORD_SIZE-1:0] ram_q,
    output logic [7:0]               tx_data,
    output logic                     tx_load,
    input  logic                     tx_ready
);

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(FB_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);

    // Registered state
    dump_state_t           r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_csum;
    logic [7:0]            r_tx_data;
    logic                  r_tx_load;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_csum_sent;   // the byte in flight is the checksum

    // Next-state values
    dump_state_t           w_state;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_csum;
    logic [7:0]            w_tx_data;
    logic                  w_tx_load;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_csum_sent;
    logic [7:0]            w_ram_byte;

    assign w_ram_byte = 8'(ram_q);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_csum      <= '0;
            r_tx_data   <= '0;
            r_tx_load   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_csum_sent <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_addr      <= w_addr;
            r_csum      <= w_csum;
            r_tx_data   <= w_tx_data;
            r_tx_load   <= w_tx_load;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_csum_sent <= w_csum_sent;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Strobes default low so tx_load
    // and done can only ever be single-cycle pulses.
    // ------------------------------------------------------------------
    always_comb begin
        w_state     = r_state;
        w_addr      = r_addr;
        w_csum      = r_csum;
        w_tx_data   = r_tx_data;
        w_tx_load   = 1'b0;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_csum_sent = r_csum_sent;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_addr      = '0;
                    w_csum      = '0;
                    w_csum_sent = 1'b0;
                    w_busy      = 1'b1;
                    w_state     = FETCH;
                end
            end

            // The address register already drives the RAM; this cycle
            // covers the RAM read latency.
            FETCH: begin
                w_state = CAPTURE;
            end

            CAPTURE: begin
                w_tx_data = w_ram_byte;
                w_csum    = r_csum ^ w_ram_byte;
                w_state   = LOAD;
            end

            LOAD: begin
                if (tx_ready) begin
                    w_tx_load = 1'b1;
                    w_state   = WAIT_ACK;
                end
            end

            // tx_ready falling is the UART's acknowledgement of the load.
            WAIT_ACK: begin
                if (!tx_ready) begin
                    w_state = WAIT_RDY;
                end
            end

            WAIT_RDY: begin
                if (tx_ready) begin
                    if (!r_csum_sent && (r_addr < c_last_addr)) begin
                        w_addr  = r_addr + c_addr_one;
                        w_state = FETCH;
                    end else if (!r_csum_sent && SEND_CHECKSUM) begin
                        w_state = CSUM;
                    end else begin
                        // done/busy change here so they are visible in DONE.
                        w_done  = 1'b1;
                        w_busy  = 1'b0;
                        w_state = DONE;
                    end
                end
            end

            CSUM: begin
                w_tx_data   = r_csum;
                w_csum_sent = 1'b1;
                w_state     = LOAD;
            end

            // start is not sampled here, so a request coinciding with
            // done is dropped.
            DONE: begin
                w_state = IDLE;
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign ram_read_address = r_addr;
    assign tx_data          = r_tx_data;
    assign tx_load          = r_tx_load;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_dumper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_framebuffer_dumper
// Description : Self-checking bench for framebuffer_dumper. Three instances:
//               a 4-byte dump with checksum, a 4-byte dump without checksum,
//               and a full-size 9600-byte dump. Each has its own RAM and
//               UART models; expected bytes come from the RAM contents and
//               an XOR reduction computed in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_framebuffer_dumper;

    localparam int SMALL = 4;
    localparam int FULL  = 9600;
    localparam int AW    = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Instance A: FB_SIZE=4 with checksum
    // ------------------------------------------------------------------
    logic          a_reset = 1'b0, a_start = 1'b0, a_block = 1'b0, a_rdy_m = 1'b1;
    logic          a_busy, a_done, a_load, a_rdy, a_prev_load = 1'b0;
    logic [AW-1:0] a_addr;
    logic [7:0]    a_q, a_txd;
    logic [7:0]    a_ram [SMALL];
    int            a_delay = 1, a_cnt = 0, a_dones = 0;
    logic [7:0]    a_bytes [$];
    logic [AW-1:0] a_addrs [$];

    assign a_rdy = a_rdy_m & ~a_block;

    framebuffer_dumper #(.FB_SIZE(SMALL), .ADDR_WIDTH(AW), .RAM_WORD_SIZE(8), .SEND_CHECKSUM(1'b1)) u_dut_a (
        .clk(clk), .reset(a_reset), .start(a_start), .busy(a_busy), .done(a_done),
        .ram_read_address(a_addr), .ram_q(a_q), .tx_data(a_txd), .tx_load(a_load), .tx_ready(a_rdy));

    always @(posedge clk) a_q <= a_ram[a_addr[1:0]];

    // UART: takes a byte on tx_load, then is busy for a_delay cycles.
    always @(posedge clk) begin
        if (a_load === 1'b1) begin
            a_rdy_m <= 1'b0;
            a_cnt   <= a_delay;
        end else if (a_cnt > 1) begin
            a_cnt <= a_cnt - 1;
        end else if (a_cnt == 1) begin
            a_cnt   <= 0;
            a_rdy_m <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (a_load === 1'b1) begin
            a_bytes.push_back(a_txd);
            a_addrs.push_back(a_addr);
            check("a_load_while_ready", a_rdy, 1);
            check("a_load_not_back_to_back", a_prev_load, 0);
        end
        if (a_done === 1'b1) a_dones++;
        a_prev_load = a_load;
    end

    // ------------------------------------------------------------------
    // Instance B: FB_SIZE=4 without checksum
    // ------------------------------------------------------------------
    logic          b_reset = 1'b0, b_start = 1'b0, b_rdy = 1'b1;
    logic          b_busy, b_done, b_load;
    logic [AW-1:0] b_addr;
    logic [7:0]    b_q, b_txd;
    logic [7:0]    b_ram [SMALL];
    int            b_cnt = 0, b_dones = 0;
    logic [7:0]    b_bytes [$];

    framebuffer_dumper #(.FB_SIZE(SMALL), .ADDR_WIDTH(AW), .RAM_WORD_SIZE(8), .SEND_CHECKSUM(1'b0)) u_dut_b (
        .clk(clk), .reset(b_reset), .start(b_start), .busy(b_busy), .done(b_done),
        .ram_read_address(b_addr), .ram_q(b_q), .tx_data(b_txd), .tx_load(b_load), .tx_ready(b_rdy));

    always @(posedge clk) b_q <= b_ram[b_addr[1:0]];

    always @(posedge clk) begin
        if (b_load === 1'b1) begin
            b_rdy <= 1'b0;
            b_cnt <= 2;
        end else if (b_cnt > 1) begin
            b_cnt <= b_cnt - 1;
        end else if (b_cnt == 1) begin
            b_cnt <= 0;
            b_rdy <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (b_load === 1'b1) b_bytes.push_back(b_txd);
        if (b_done === 1'b1) b_dones++;
    end

    // ------------------------------------------------------------------
    // Instance C: full size, RAM holds addr mod 256
    // ------------------------------------------------------------------
    logic          c_reset = 1'b0, c_start = 1'b0, c_rdy = 1'b1;
    logic          c_busy, c_done, c_load;
    logic [AW-1:0] c_addr;
    logic [7:0]    c_q, c_txd, c_last = 8'h0, c_csb = 8'h0;
    int            c_cnt = 0, c_n = 0, c_bad = 0;

    framebuffer_dumper #(.FB_SIZE(FULL), .ADDR_WIDTH(AW), .RAM_WORD_SIZE(8), .SEND_CHECKSUM(1'b1)) u_dut_c (
        .clk(clk), .reset(c_reset), .start(c_start), .busy(c_busy), .done(c_done),
        .ram_read_address(c_addr), .ram_q(c_q), .tx_data(c_txd), .tx_load(c_load), .tx_ready(c_rdy));

    always @(posedge clk) c_q <= 8'(int'(c_addr) % 256);

    always @(posedge clk) begin
        if (c_load === 1'b1) begin
            c_rdy <= 1'b0;
            c_cnt <= 1;
        end else if (c_cnt == 1) begin
            c_cnt <= 0;
            c_rdy <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (c_load === 1'b1) begin
            if (c_n < FULL) begin
                if (c_txd !== 8'(c_n % 256)) c_bad++;
                if (c_n == FULL - 1) c_last = c_txd;
            end else if (c_n == FULL) begin
                c_csb = c_txd;
            end
            c_n++;
        end
    end

    // ------------------------------------------------------------------
    // Vectors for instance A
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [SMALL-1:0][7:0] ram;    // ram[0] is the rightmost element
        logic [7:0]            delay;  // UART busy time after each load
        logic                  poke;   // extra start during byte 2 and on done
        logic [7:0]            block;  // cycles tx_ready is held low at start
        logic [7:0]            csum;   // expected checksum byte
    } vec_t;

    localparam int NVEC = 6;
    vec_t tbl [NVEC];

    function automatic logic [7:0] xor_of(input logic [SMALL-1:0][7:0] r);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < SMALL; i++) x = x ^ r[i];
        return x;
    endfunction

    task automatic run_a(input string name, input vec_t v);
        int   cyc;
        int   busy_bad;
        int   slow_bad;
        bit   poked;
        logic [7:0] held;
        cyc = 0; busy_bad = 0; slow_bad = 0; poked = 0; held = 8'h0;
        a_bytes.delete();
        a_addrs.delete();
        a_dones = 0;
        for (int i = 0; i < SMALL; i++) a_ram[i] = v.ram[i];
        a_delay = int'(v.delay);
        a_block = (v.block != 8'd0);

        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        check({name, "_busy_rise"}, a_busy, 1);
        check({name, "_addr0"}, a_addr, 0);

        while (a_done !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (v.block != 8'd0) begin
                if (cyc == 3) held = a_txd;
                if (cyc > 3 && cyc <= int'(v.block) && a_txd !== held) slow_bad++;
                if (cyc == int'(v.block)) begin
                    check({name, "_slow_no_load"}, a_bytes.size(), 0);
                    check({name, "_slow_data_stable"}, slow_bad, 0);
                    a_block = 1'b0;
                end
            end
            if (v.poke && !poked && a_bytes.size() == 2) begin
                a_start = 1'b1;
                poked   = 1'b1;
            end else begin
                a_start = 1'b0;
            end
            if (a_done !== 1'b1 && a_busy !== 1'b1) busy_bad++;
        end
        check({name, "_done_seen"}, a_done, 1);
        check({name, "_busy_low_at_done"}, a_busy, 0);
        check({name, "_busy_span"}, busy_bad, 0);

        // A start coinciding with done must be ignored.
        if (v.poke) a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        repeat (3) @(negedge clk);
        check({name, "_no_restart"}, a_busy, 0);
        check({name, "_done_once"}, a_dones, 1);

        check({name, "_nbytes"}, a_bytes.size(), SMALL + 1);
        if (a_bytes.size() == SMALL + 1) begin
            for (int i = 0; i < SMALL; i++) begin
                check($sformatf("%s_byte%0d", name, i), a_bytes[i], v.ram[i]);
                check($sformatf("%s_addr%0d", name, i), a_addrs[i], i);
            end
            check({name, "_csum"}, a_bytes[SMALL], v.csum);
        end
    endtask

    vec_t rv;
    int   rcyc, rloads, bcyc, ccyc;
    logic [7:0] c_exp;

    initial begin
        // Packed lists are written highest index first.
        tbl[0] = '{ram: {8'h88, 8'h44, 8'h22, 8'h11}, delay: 8'd10, poke: 1'b0, block: 8'd0,   csum: 8'hFF};
        tbl[1] = '{ram: {8'h08, 8'h04, 8'h02, 8'h01}, delay: 8'd1,  poke: 1'b0, block: 8'd0,   csum: 8'h0F};
        tbl[2] = '{ram: {8'h00, 8'h00, 8'hFF, 8'hFF}, delay: 8'd3,  poke: 1'b0, block: 8'd0,   csum: 8'h00};
        tbl[3] = '{ram: {8'h01, 8'h00, 8'h5A, 8'hA5}, delay: 8'd6,  poke: 1'b0, block: 8'd0,   csum: 8'hFE};
        tbl[4] = '{ram: {8'h40, 8'h30, 8'h20, 8'h10}, delay: 8'd5,  poke: 1'b1, block: 8'd0,   csum: 8'h40};
        tbl[5] = '{ram: {8'h01, 8'h3C, 8'hC3, 8'h5A}, delay: 8'd2,  poke: 1'b0, block: 8'd200, csum: 8'hA4};
        for (int i = 0; i < SMALL; i++) begin
            a_ram[i] = 8'h00;
            b_ram[i] = 8'h00;
        end

        // Reset values
        #2;
        a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
        #2;
        check("rst_a_outputs", {a_busy, a_done, a_load, a_txd, 2'b00, a_addr}, 0);
        check("rst_b_outputs", {b_busy, b_done, b_load, b_txd, 2'b00, b_addr}, 0);
        check("rst_c_outputs", {c_busy, c_done, c_load, c_txd, 2'b00, c_addr}, 0);
        @(negedge clk);
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;

        fork
            begin : t_small
                for (int k = 0; k < NVEC; k++) run_a($sformatf("vec%0d", k), tbl[k]);

                // Reset during WAIT_ACK of byte 1, then a fresh dump.
                for (int i = 0; i < SMALL; i++) a_ram[i] = 8'hE0 + 8'(i);
                a_delay = 4;
                rcyc = 0; rloads = 0;
                @(negedge clk); a_start = 1'b1;
                @(negedge clk); a_start = 1'b0;
                while (rloads < 2 && rcyc < 500) begin
                    @(negedge clk);
                    rcyc++;
                    if (a_load === 1'b1) rloads++;
                end
                check("midrst_reached_byte1", rloads, 2);
                #1 a_reset = 1'b1;
                #1 check("midrst_outputs_zero", {a_busy, a_done, a_load, a_txd, 2'b00, a_addr}, 0);
                @(negedge clk); a_reset = 1'b0;
                run_a("after_rst", '{ram: {8'hC0, 8'h33, 8'hF0, 8'h0F}, delay: 8'd2, poke: 1'b0, block: 8'd0, csum: 8'h0C});

                // Random contents and UART timing against the XOR model.
                for (int k = 0; k < 6; k++) begin
                    for (int i = 0; i < SMALL; i++) rv.ram[i] = 8'($urandom);
                    rv.delay = 8'($urandom_range(1, 12));
                    rv.poke  = 1'b0;
                    rv.block = 8'd0;
                    rv.csum  = xor_of(rv.ram);
                    run_a($sformatf("rand%0d", k), rv);
                end
            end

            begin : t_nocsum
                b_ram[0] = 8'h12; b_ram[1] = 8'h34; b_ram[2] = 8'h56; b_ram[3] = 8'h78;
                bcyc = 0;
                @(negedge clk); b_start = 1'b1;
                @(negedge clk); b_start = 1'b0;
                while (b_done !== 1'b1 && bcyc < 2000) begin
                    @(negedge clk);
                    bcyc++;
                end
                check("nocsum_done_seen", b_done, 1);
                repeat (3) @(negedge clk);
                check("nocsum_loads", b_bytes.size(), SMALL);
                check("nocsum_done_once", b_dones, 1);
                if (b_bytes.size() == SMALL) begin
                    check("nocsum_byte0", b_bytes[0], 8'h12);
                    check("nocsum_byte3", b_bytes[3], 8'h78);
                end
            end

            begin : t_full
                c_exp = 8'h00;
                for (int i = 0; i < FULL; i++) c_exp = c_exp ^ 8'(i % 256);
                ccyc = 0;
                @(negedge clk); c_start = 1'b1;
                @(negedge clk); c_start = 1'b0;
                while (c_done !== 1'b1 && ccyc < 80000) begin
                    @(negedge clk);
                    ccyc++;
                end
                check("full_done_seen", c_done, 1);
                repeat (2) @(negedge clk);
                check("full_byte_count", c_n, FULL + 1);
                check("full_data_pattern_errors", c_bad, 0);
                check("full_last_data", c_last, 8'h7F);
                check("full_csum_model", c_csb, c_exp);
                check("full_csum_value", c_csb, 8'h00);
            end
        join

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
